lif_neuron_ctrl: RTL

Sequencing controller for one leaky integrate-and-fire neuron. On each `step` tick it applies leak and input current to the membrane state register, compares against threshold, emits a spike, and enforces a refractory period. It sits between the input-current source and the spike output logic, and owns both the membrane state register and the previous-state register.

---
 rtl/lif_pkg.sv | 16 +
 rtl/lif_neuron_ctrl_if.sv | 28 ++
 rtl/lif_neuron_ctrl_update.sv | 22 ++
 rtl/lif_neuron_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire neuron controller.
package lif_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      REFRACT = 1'b1
   } mode_t;

   localparam int DEF_WIDTH         = 8;
   localparam int DEF_LEAK_SHIFT    = 2;
   localparam int DEF_REFRACT_STEPS = 3;

   localparam int          SAT_MAX       = (1 << DEF_WIDTH) - 1;
   localparam logic [7:0]  SPIKE_CNT_MAX = 8'hFF;

endpackage

// File: rtl/lif_neuron_ctrl_if.sv
// Step/current/threshold inputs and neuron outputs of one LIF neuron.
// LIAF_SPIKE_COUNT_EN adds the saturating spike_count output.
interface lif_neuron_ctrl_if
   import lif_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             step;
   logic [WIDTH-1:0] current;
   logic [WIDTH-1:0] threshold;
   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] prev_state;
   logic             spike;
   logic             refractory;
`ifdef LIAF_SPIKE_COUNT_EN
   logic [7:0]       spike_count;

   modport master (output step, current, threshold,
                   input  state, prev_state, spike, refractory, spike_count);
   modport slave  (input  step, current, threshold,
                   output state, prev_state, spike, refractory, spike_count);
`else
   modport master (output step, current, threshold,
                   input  state, prev_state, spike, refractory);
   modport slave  (input  step, current, threshold,
                   output state, prev_state, spike, refractory);
`endif
endinterface

// File: rtl/lif_neuron_ctrl_update.sv
// Combinational membrane update: leak, saturating add of input current, threshold compare.
module lif_update
   import lif_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
   input  logic [WIDTH-1:0] state,
   input  logic [WIDTH-1:0] current,
   input  logic [WIDTH-1:0] threshold,
   output logic [WIDTH-1:0] nxt,
   output logic             fire
);
   logic [WIDTH-1:0] leaked;
   logic [WIDTH:0]   sum;

   // state >> LEAK_SHIFT never exceeds state, so this cannot wrap.
   assign leaked = state - (state >> LEAK_SHIFT);
   assign sum    = {1'b0, leaked} + {1'b0, current};
   assign nxt    = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
   assign fire   = (nxt >= threshold);
endmodule

// File: rtl/lif_neuron_ctrl.sv
// LIF neuron controller: RUN/REFRACT mode FSM, refractory counter and all output registers.
// Optional LIAF_SPIKE_COUNT_EN adds a saturating 8-bit firing counter.
module lif_neuron_ctrl
   import lif_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT,
   parameter int REFRACT_STEPS = DEF_REFRACT_STEPS
) (
   input  logic              clk,
   input  logic              reset_n,
   lif_neuron_ctrl_if.slave  bus
);
   localparam int CW = (REFRACT_STEPS < 1) ? 1 : $clog2(REFRACT_STEPS + 1);

   mode_t            mode;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] prev_q;
   logic             spike_q;
   logic             refr_q;
   logic [WIDTH-1:0] nxt;
   logic             fire;

   lif_update #(
      .WIDTH      (WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_update (
      .state     (state_q),
      .current   (bus.current),
      .threshold (bus.threshold),
      .nxt       (nxt),
      .fire      (fire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode    <= RUN;
         cnt     <= '0;
         state_q <= '0;
         prev_q  <= '0;
         spike_q <= 1'b0;
         refr_q  <= 1'b0;
      end else begin
         spike_q <= 1'b0;
         if (bus.step) begin
            prev_q <= state_q;
            case (mode)
               RUN: begin
                  if (fire) begin
                     state_q <= '0;
                     spike_q <= 1'b1;
                     // With no refractory period the neuron may fire on every step.
                     if (REFRACT_STEPS != 0) begin
                        mode   <= REFRACT;
                        refr_q <= 1'b1;
                        cnt    <= CW'(REFRACT_STEPS);
                     end
                  end else begin
                     state_q <= nxt;
                  end
               end
               REFRACT: begin
                  state_q <= '0;
                  cnt     <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     mode   <= RUN;
                     refr_q <= 1'b0;
                  end
               end
               default: mode <= RUN;
            endcase
         end
      end
   end

   assign bus.state      = state_q;
   assign bus.prev_state = prev_q;
   assign bus.spike      = spike_q;
   assign bus.refractory = refr_q;

`ifdef LIAF_SPIKE_COUNT_EN
   logic [7:0] spike_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spike_cnt_q <= '0;
      end else if (bus.step && mode == RUN && fire && spike_cnt_q != SPIKE_CNT_MAX) begin
         spike_cnt_q <= spike_cnt_q + 8'd1;
      end
   end

   assign bus.spike_count = spike_cnt_q;
`endif
endmodule
